// File: rtl/multicycle_cu_if.sv
// multicycle_cu_if: handshake and control bundle between the sequencing FSM and the datapath.
// master is the controller side, slave is the datapath/memory side.
interface multicycle_cu_if;
   logic       run;
   logic [2:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       PCSource;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemToReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       busy;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  run, opcode, mem_ready,
      output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
             MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             busy, instr_done, illegal
   );

   modport slave (
      output run, opcode, mem_ready,
      input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
             MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             busy, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle sequencing FSM (fetch/decode/execute/memory/writeback) for the 16-bit CPU.
// Defining INSTR_COUNT_EN adds the COUNT_W-bit retired-instruction counter output instr_count.
module multicycle_cu #(
   parameter int COUNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_cu_if.master  bus
`ifdef INSTR_COUNT_EN
   ,
   output logic [COUNT_W-1:0] instr_count
`endif
);

   typedef enum logic [3:0] {
      sIdle, sFetch, sDecode, sMemAddr, sMemRead, sMemWb,
      sMemWrite, sExec, sAluWb, sBranch
   } stateT;

   localparam logic [2:0] OP_R    = 3'b111;
   localparam logic [2:0] OP_ADDI = 3'b100;
   localparam logic [2:0] OP_SLLI = 3'b101;
   localparam logic [2:0] OP_LW   = 3'b000;
   localparam logic [2:0] OP_SW   = 3'b001;
   localparam logic [2:0] OP_BEQ  = 3'b011;

   typedef struct packed {
      logic       pcWriteCond;
      logic       pcSource;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       busy;
      logic       doneFixed;
   } ctrlT;

   stateT      state;
   stateT      nextState;
   stateT      finishState;
   logic [2:0] opQ;
   logic [2:0] opNext;
   ctrlT       ctrlQ;
   logic       opIllegal;
   logic       illegalPulse;
   logic       doneNow;

   // Per-state controls that depend only on state and the latched opcode.
   function automatic ctrlT stateCtrl(input stateT s, input logic [2:0] op);
      ctrlT c;
      c      = '0;
      c.busy = (s != sIdle);
      case (s)
         sFetch:    begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
         sDecode:   c.aluSrcB = 2'b11;
         sMemAddr:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
         sMemRead:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
         sMemWb:    begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.doneFixed = 1'b1; end
         sMemWrite: begin c.memWrite = 1'b1; c.iorD = 1'b1; end
         sExec: begin
            c.aluSrcA = 1'b1;
            c.aluOp   = 2'b10;
            c.aluSrcB = (op == OP_R) ? 2'b00 : 2'b10;
         end
         sAluWb: begin
            c.regWrite  = 1'b1;
            c.regDst    = (op == OP_R);
            c.doneFixed = 1'b1;
         end
         sBranch: begin
            c.aluSrcA     = 1'b1;
            c.aluOp       = 2'b01;
            c.pcWriteCond = 1'b1;
            c.pcSource    = 1'b1;
            c.doneFixed   = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      opIllegal = 1'b1;
      case (bus.opcode)
         OP_R, OP_ADDI, OP_SLLI, OP_LW, OP_SW, OP_BEQ: opIllegal = 1'b0;
         default: ;
      endcase
   end

   assign finishState = bus.run ? sFetch : sIdle;

   // The opcode is latched on leaving DECODE, so the registered controls for that
   // transition must look at the live opcode; every later state uses opQ.
   always_comb begin
      nextState = state;
      opNext    = (state == sDecode) ? bus.opcode : opQ;
      case (state)
         sIdle:     nextState = bus.run ? sFetch : sIdle;
         sFetch:    nextState = bus.mem_ready ? sDecode : sFetch;
         sDecode: begin
            case (bus.opcode)
               OP_LW, OP_SW:            nextState = sMemAddr;
               OP_R, OP_ADDI, OP_SLLI:  nextState = sExec;
               OP_BEQ:                  nextState = sBranch;
               default:                 nextState = finishState;
            endcase
         end
         sMemAddr:  nextState = (opQ == OP_LW) ? sMemRead : sMemWrite;
         sMemRead:  nextState = bus.mem_ready ? sMemWb : sMemRead;
         sMemWb:    nextState = finishState;
         sMemWrite: nextState = bus.mem_ready ? finishState : sMemWrite;
         sExec:     nextState = sAluWb;
         sAluWb:    nextState = finishState;
         sBranch:   nextState = finishState;
         default:   nextState = sIdle;
      endcase
   end

   // State, latched opcode and the registered controls for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= sIdle;
         opQ   <= '0;
         ctrlQ <= '0;
      end else begin
         state <= nextState;
         if (state == sDecode) begin
            opQ <= bus.opcode;
         end
         ctrlQ <= stateCtrl(nextState, opNext);
      end
   end

   // Strobes that react to the memory handshake or the freshly loaded IR in the same cycle.
   assign illegalPulse = (state == sDecode) && opIllegal;
   assign doneNow      = ctrlQ.doneFixed | illegalPulse | (ctrlQ.memWrite & bus.mem_ready);

   assign bus.PCWrite     = (state == sFetch) && bus.mem_ready;
   assign bus.IRWrite     = (state == sFetch) && bus.mem_ready;
   assign bus.PCWriteCond = ctrlQ.pcWriteCond;
   assign bus.PCSource    = ctrlQ.pcSource;
   assign bus.IorD        = ctrlQ.iorD;
   assign bus.MemRead     = ctrlQ.memRead;
   assign bus.MemWrite    = ctrlQ.memWrite;
   assign bus.MemToReg    = ctrlQ.memToReg;
   assign bus.RegDst      = ctrlQ.regDst;
   assign bus.RegWrite    = ctrlQ.regWrite;
   assign bus.ALUSrcA     = ctrlQ.aluSrcA;
   assign bus.ALUSrcB     = ctrlQ.aluSrcB;
   assign bus.ALUOp       = ctrlQ.aluOp;
   assign bus.busy        = ctrlQ.busy;
   assign bus.instr_done  = doneNow;
   assign bus.illegal     = illegalPulse;

`ifdef INSTR_COUNT_EN
   // Retired-instruction counter; wraps naturally at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
      end else if (doneNow) begin
         instr_count <= instr_count + COUNT_W'(1);
      end
   end
`else
   logic unusedCountW;
   assign unusedCountW = ^COUNT_W;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: directed checks of the multi-cycle control FSM, one output snapshot per cycle.
// With INSTR_COUNT_EN defined it also checks the 4-bit retired-instruction counter wrap.
module tb_multicycle_cu;

   logic clk = 1'b0;
   logic reset;
   int   assertCount = 0;
   int   failCount   = 0;

   multicycle_cu_if bus ();

`ifdef INSTR_COUNT_EN
   logic [3:0] instrCount;
`endif

   multicycle_cu #(.COUNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef INSTR_COUNT_EN
      ,
      .instr_count (instrCount)
`endif
   );

   always #5 clk = ~clk;

   // Field order: PCWrite PCWriteCond PCSource IorD MemRead MemWrite IRWrite MemToReg
   // RegDst RegWrite ALUSrcA | ALUSrcB | ALUOp | busy instr_done illegal
   logic [17:0] observedCtrl;
   assign observedCtrl = {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
                          bus.MemWrite, bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite,
                          bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.busy, bus.instr_done, bus.illegal};

   localparam logic [17:0] eIdle         = '0;
   localparam logic [17:0] eFetchWait    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eFetchRdy     = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eDecode       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eDecodeIll    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11, 2'b00, 1'b1,1'b1,1'b1};
   localparam logic [17:0] eMemAddr      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eMemRead      = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eMemWb        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00, 2'b00, 1'b1,1'b1,1'b0};
   localparam logic [17:0] eMemWriteWait = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eMemWriteRdy  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 2'b00, 1'b1,1'b1,1'b0};
   localparam logic [17:0] eExecR        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b10, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eExecI        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 2'b10, 1'b1,1'b0,1'b0};
   localparam logic [17:0] eAluWbR       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00, 2'b00, 1'b1,1'b1,1'b0};
   localparam logic [17:0] eAluWbI       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00, 2'b00, 1'b1,1'b1,1'b0};
   localparam logic [17:0] eBranch       = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 2'b01, 1'b1,1'b1,1'b0};

   // Inputs change on the falling edge so the FSM sees them stable at the next rising edge.
   task automatic applyStimulus(input logic runIn, input logic [2:0] opIn, input logic readyIn);
      @(negedge clk);
      bus.run       = runIn;
      bus.opcode    = opIn;
      bus.mem_ready = readyIn;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [17:0] expected);
      assertCount++;
      assert (observedCtrl === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observedCtrl, expected);
      end
   endtask

`ifdef INSTR_COUNT_EN
   task automatic checkCount(input string tag, input logic [3:0] expected);
      assertCount++;
      assert (instrCount === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, instrCount, expected);
      end
   endtask
`endif

   initial begin
      reset         = 1'b1;
      bus.run       = 1'b0;
      bus.opcode    = 3'b000;
      bus.mem_ready = 1'b0;

      $display("[TB] reset and idle");
      applyStimulus(1'b0, 3'b000, 1'b0); reset = 1'b0; checkOutput("reset idle", eIdle);
      applyStimulus(1'b0, 3'b000, 1'b1); checkOutput("idle hold", eIdle);
`ifdef INSTR_COUNT_EN
      checkCount("count reset", 4'd0);
`endif

      $display("[TB] R-type, zero wait");
      applyStimulus(1'b1, 3'b111, 1'b1); checkOutput("r idle sees run", eIdle);
      applyStimulus(1'b1, 3'b111, 1'b1); checkOutput("r fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b111, 1'b1); checkOutput("r decode", eDecode);
      applyStimulus(1'b1, 3'b111, 1'b1); checkOutput("r exec", eExecR);
      applyStimulus(1'b1, 3'b111, 1'b1); checkOutput("r alu_wb", eAluWbR);

      $display("[TB] LW with three read wait cycles");
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("lw fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("lw decode", eDecode);
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("lw mem_addr", eMemAddr);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("lw read wait1", eMemRead);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("lw read wait2", eMemRead);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("lw read wait3", eMemRead);
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("lw read done", eMemRead);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("lw mem_wb", eMemWb);

      $display("[TB] SW then BEQ");
      applyStimulus(1'b1, 3'b001, 1'b1); checkOutput("sw fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b001, 1'b1); checkOutput("sw decode", eDecode);
      applyStimulus(1'b1, 3'b001, 1'b0); checkOutput("sw mem_addr", eMemAddr);
      applyStimulus(1'b1, 3'b001, 1'b0); checkOutput("sw write wait", eMemWriteWait);
      applyStimulus(1'b1, 3'b001, 1'b1); checkOutput("sw write done", eMemWriteRdy);
      applyStimulus(1'b1, 3'b011, 1'b0); checkOutput("beq fetch wait", eFetchWait);
      applyStimulus(1'b1, 3'b011, 1'b1); checkOutput("beq fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b011, 1'b1); checkOutput("beq decode", eDecode);
      applyStimulus(1'b1, 3'b011, 1'b1); checkOutput("beq branch", eBranch);

      $display("[TB] illegal opcodes");
      applyStimulus(1'b1, 3'b110, 1'b1); checkOutput("ill110 fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b110, 1'b1); checkOutput("ill110 decode", eDecodeIll);
      applyStimulus(1'b1, 3'b010, 1'b0); checkOutput("ill back to fetch", eFetchWait);
      applyStimulus(1'b1, 3'b010, 1'b1); checkOutput("ill010 fetch", eFetchRdy);
      applyStimulus(1'b0, 3'b010, 1'b1); checkOutput("ill010 decode", eDecodeIll);
      applyStimulus(1'b0, 3'b010, 1'b1); checkOutput("ill to idle", eIdle);

      $display("[TB] run drop and opcode change mid-instruction");
      applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("addi idle sees run", eIdle);
      applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("addi fetch", eFetchRdy);
      applyStimulus(1'b0, 3'b100, 1'b1); checkOutput("addi decode", eDecode);
      applyStimulus(1'b0, 3'b111, 1'b1); checkOutput("addi exec op changed", eExecI);
      applyStimulus(1'b0, 3'b111, 1'b1); checkOutput("addi alu_wb latched op", eAluWbI);
      applyStimulus(1'b0, 3'b111, 1'b1); checkOutput("addi then idle", eIdle);

      $display("[TB] reset during read wait");
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("abort idle sees run", eIdle);
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("abort fetch", eFetchRdy);
      applyStimulus(1'b1, 3'b000, 1'b1); checkOutput("abort decode", eDecode);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("abort mem_addr", eMemAddr);
      applyStimulus(1'b1, 3'b000, 1'b0); checkOutput("abort read wait", eMemRead);
      reset = 1'b1;
      applyStimulus(1'b0, 3'b000, 1'b1); reset = 1'b0; checkOutput("abort forced idle", eIdle);
      applyStimulus(1'b0, 3'b000, 1'b1); checkOutput("abort stays idle", eIdle);

`ifdef INSTR_COUNT_EN
      $display("[TB] counter wrap over 17 ADDI");
      checkCount("count after abort reset", 4'd0);
      applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("cnt idle sees run", eIdle);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("cnt fetch", eFetchRdy);
         applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("cnt decode", eDecode);
         applyStimulus(1'b1, 3'b100, 1'b1); checkOutput("cnt exec", eExecI);
         applyStimulus((i != 16), 3'b100, 1'b1); checkOutput("cnt alu_wb", eAluWbI);
      end
      applyStimulus(1'b0, 3'b100, 1'b1); checkOutput("cnt idle", eIdle);
      checkCount("count wrapped", 4'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
